// File: rtl/led_driver_pkg.sv
// Shared types and constants for the LED driver.
// Holds the register map, register layouts, LEDOUT field encodings, the
// group-mode enum and the register reset values used by led_pwm_ctrl.
package led_driver_pkg;

    localparam int ADDR_BITS = 3;
    localparam int DATA_BITS = 8;

    typedef enum logic [ADDR_BITS-1:0] {
        REG_MODE    = 3'd0,
        REG_PWM0    = 3'd1,
        REG_PWM1    = 3'd2,
        REG_PWM2    = 3'd3,
        REG_PWM3    = 3'd4,
        REG_GRPPWM  = 3'd5,
        REG_GRPFREQ = 3'd6,
        REG_LEDOUT  = 3'd7
    } reg_enum_t;

    typedef enum logic [1:0] {
        LED_OFF        = 2'd0,
        LED_ON         = 2'd1,
        LED_INDIVIDUAL = 2'd2,
        LED_GROUP      = 2'd3
    } led_out_enum_t;

    // MODE register layout, bit 7 down to bit 0.
    typedef struct packed {
        logic       auto_increment;
        logic       sleep;
        logic       dim_blink;
        logic       invert;
        logic       output_change;
        logic [1:0] spare;
        logic       reserved;
    } reg_mode_t;

    // LEDOUT register: two bits per LED, LED0 in the low bits.
    typedef struct packed {
        led_out_enum_t led3;
        led_out_enum_t led2;
        led_out_enum_t led1;
        led_out_enum_t led0;
    } reg_led_out_t;

    typedef enum logic {
        GRP_DIM   = 1'b0,
        GRP_BLINK = 1'b1
    } grp_mode_t;

    localparam logic [DATA_BITS-1:0] MODE_RST    = 8'h00;
    localparam logic [DATA_BITS-1:0] PWM_RST     = 8'h00;
    localparam logic [DATA_BITS-1:0] GRPPWM_RST  = 8'hFF;
    localparam logic [DATA_BITS-1:0] GRPFREQ_RST = 8'h00;
    localparam logic [DATA_BITS-1:0] LEDOUT_RST  = 8'h00;

endpackage

// File: rtl/led_pwm_timebase.sv
// PWM timebase: prescaler, 8-bit PWM counter and the group dim/blink gate.
// Ports:
//   clk, reset     system clock, synchronous active-low reset
//   hold           sleep: all counters held at 0
//   grp_mode       GRP_DIM or GRP_BLINK
//   grppwm         group duty threshold
//   grpfreq        blink sub-period length minus one (in PWM periods)
//   pwm_cnt        current PWM counter value
//   period_end     last step of a PWM period (pwm_cnt wraps on this cycle)
//   gate           group enable for LEDs in GROUP mode
module led_pwm_timebase
    import led_driver_pkg::*;
#(
    parameter int PWM_DIV = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       hold,
    input  grp_mode_t  grp_mode,
    input  logic [7:0] grppwm,
    input  logic [7:0] grpfreq,
    output logic [7:0] pwm_cnt,
    output logic       period_end,
    output logic       gate
);

    localparam int DIV_W = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;

    logic [DIV_W-1:0] div_cnt;
    logic [7:0]       dim_cnt;
    logic [7:0]       sub_cnt;
    logic [7:0]       blink_phase;
    grp_mode_t        grp_mode_q;
    logic             step;

    assign step       = (div_cnt == DIV_W'(PWM_DIV - 1));
    assign period_end = step && (pwm_cnt == 8'hFF);

    always_comb begin
        gate = 1'b0;
        if (grp_mode == GRP_BLINK) gate = (blink_phase < grppwm);
        else                       gate = (dim_cnt < grppwm);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            div_cnt     <= '0;
            pwm_cnt     <= '0;
            dim_cnt     <= '0;
            sub_cnt     <= '0;
            blink_phase <= '0;
            grp_mode_q  <= GRP_DIM;
        end else begin
            // Tracked even in sleep so a mode change during sleep does not
            // trigger a second clear on wake-up.
            grp_mode_q <= grp_mode;
            if (hold) begin
                div_cnt     <= '0;
                pwm_cnt     <= '0;
                dim_cnt     <= '0;
                sub_cnt     <= '0;
                blink_phase <= '0;
            end else begin
                div_cnt <= step ? '0 : div_cnt + 1'b1;
                if (step) pwm_cnt <= pwm_cnt + 8'd1;

                if (grp_mode != grp_mode_q) begin
                    // Switching between dim and blink restarts the group pattern.
                    dim_cnt     <= '0;
                    sub_cnt     <= '0;
                    blink_phase <= '0;
                end else if (period_end) begin
                    if (grp_mode == GRP_DIM) begin
                        dim_cnt <= dim_cnt + 8'd1;
                    end else if (sub_cnt == grpfreq) begin
                        sub_cnt     <= '0;
                        blink_phase <= blink_phase + 8'd1;
                    end else begin
                        sub_cnt <= sub_cnt + 8'd1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/led_pwm_ctrl.sv
// LED driver register bank and PWM output stage.
// Ports:
//   clk     system clock
//   reset   synchronous active-low reset
//   sleep   global sleep, OR'd with MODE.sleep
//   addr    register address (reg_enum_t)
//   r_en    read strobe; data driven combinationally when r_en && !w_en
//   w_en    write strobe; reg[addr] <= data at the clock edge
//   data    shared tri-state data bus
//   led     registered LED drive, bit i = LEDi
module led_pwm_ctrl
    import led_driver_pkg::*;
#(
    parameter int PWM_DIV = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sleep,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic                 r_en,
    input  logic                 w_en,
    inout  wire  [DATA_BITS-1:0] data,
    output logic [3:0]           led
);

    reg_mode_t      mode_q;
    logic [7:0]     pwm_q [4];
    logic [7:0]     grppwm_q;
    logic [7:0]     grpfreq_q;
    reg_led_out_t   ledout_q;

    logic [7:0]     rd_data;
    logic           hold;
    logic [7:0]     pwm_cnt;
    logic           period_end;
    logic           gate;
    logic [3:0]     raw;
    led_out_enum_t  sel [4];

    assign hold = sleep | mode_q.sleep;

    always_ff @(posedge clk) begin
        if (!reset) begin
            mode_q    <= reg_mode_t'(MODE_RST);
            pwm_q[0]  <= PWM_RST;
            pwm_q[1]  <= PWM_RST;
            pwm_q[2]  <= PWM_RST;
            pwm_q[3]  <= PWM_RST;
            grppwm_q  <= GRPPWM_RST;
            grpfreq_q <= GRPFREQ_RST;
            ledout_q  <= reg_led_out_t'(LEDOUT_RST);
        end else if (w_en) begin
            case (reg_enum_t'(addr))
                REG_MODE:    mode_q    <= reg_mode_t'({data[7:1], 1'b0});
                REG_PWM0:    pwm_q[0]  <= data;
                REG_PWM1:    pwm_q[1]  <= data;
                REG_PWM2:    pwm_q[2]  <= data;
                REG_PWM3:    pwm_q[3]  <= data;
                REG_GRPPWM:  grppwm_q  <= data;
                REG_GRPFREQ: grpfreq_q <= data;
                REG_LEDOUT:  ledout_q  <= reg_led_out_t'(data);
            endcase
        end
    end

    always_comb begin
        rd_data = '0;
        case (reg_enum_t'(addr))
            REG_MODE:    rd_data = mode_q;
            REG_PWM0:    rd_data = pwm_q[0];
            REG_PWM1:    rd_data = pwm_q[1];
            REG_PWM2:    rd_data = pwm_q[2];
            REG_PWM3:    rd_data = pwm_q[3];
            REG_GRPPWM:  rd_data = grppwm_q;
            REG_GRPFREQ: rd_data = grpfreq_q;
            REG_LEDOUT:  rd_data = ledout_q;
        endcase
    end

    // A simultaneous write owns the bus, so the read side stays off.
    assign data = (r_en && !w_en) ? rd_data : 'z;

    led_pwm_timebase #(
        .PWM_DIV (PWM_DIV)
    ) u_timebase (
        .clk        (clk),
        .reset      (reset),
        .hold       (hold),
        .grp_mode   (grp_mode_t'(mode_q.dim_blink)),
        .grppwm     (grppwm_q),
        .grpfreq    (grpfreq_q),
        .pwm_cnt    (pwm_cnt),
        .period_end (period_end),
        .gate       (gate)
    );

    always_comb begin
        sel[0] = ledout_q.led0;
        sel[1] = ledout_q.led1;
        sel[2] = ledout_q.led2;
        sel[3] = ledout_q.led3;
        raw    = '0;
        for (int i = 0; i < 4; i++) begin
            case (sel[i])
                LED_OFF:        raw[i] = 1'b0;
                LED_ON:         raw[i] = 1'b1;
                LED_INDIVIDUAL: raw[i] = (pwm_cnt < pwm_q[i]);
                LED_GROUP:      raw[i] = (pwm_cnt < pwm_q[i]) & gate;
            endcase
            raw[i] = raw[i] ^ mode_q.invert;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            led <= '0;
        end else if (hold) begin
            led <= {4{mode_q.invert}};
        end else if (!mode_q.output_change || period_end) begin
            // With output_change set, duty/mode edits only reach the pins
            // at a period boundary, so no truncated pulses are emitted.
            led <= raw;
        end
    end

endmodule

// File: doc/led_pwm_ctrl.md
Name: led_pwm_ctrl

Overview:
- Register-bank and PWM output stage of the LED driver; sits directly downstream of the I2C control block.
- Consumes register read/write accesses through the bus_if led_ctrl modport (addr, r_en, w_en, inout data).
- Holds the 8 registers (MODE, PWM0-3, GRPPWM, GRPFREQ, LEDOUT) and drives 4 LED outputs with individual PWM, group dim/blink, invert and sleep control.

Parameters:
- PWM_DIV, 1, clocks per PWM counter step; must be >= 1.
- ADDR_BITS, 3, from led_driver_pkg; register address width.
- DATA_BITS, 8, from led_driver_pkg; register width.

Ports:
- clk  input  1  system clock; the only clock.
- reset  input  1  synchronous, active-low reset.
- sleep  input  1  global sleep (global_if); OR'd with MODE.sleep.
- addr  input  ADDR_BITS  register address (reg_enum_t).
- r_en  input  1  read strobe.
- w_en  input  1  write strobe.
- data  inout  DATA_BITS  shared tri-state data bus.
- led  output  4  LED drive, bit i = LEDi.

Behaviour:
- Reset (reset==0 at a clk edge):
  - MODE=0x00, PWM0-3=0x00, GRPPWM=0xFF, GRPFREQ=0x00, LEDOUT=0x00.
  - All counters = 0; led = 4'b0000; data released (Z).
  - Reset asserted mid-operation aborts everything within that edge.
- Write:
  - w_en==1 at a clk edge: reg[addr] <= data.
  - MODE.reserved (bit0) is always stored as 0.
  - MODE.auto_increment is stored but has no effect in this block.
- Read:
  - r_en==1 && w_en==0: data = reg[addr], combinational (same-cycle).
  - Otherwise data = 'z.
  - r_en and w_en both high: the write occurs and data is not driven.
- Read-after-write: a read in the cycle after a write returns the new value.
- Prescaler:
  - div_cnt counts 0..PWM_DIV-1; step = (div_cnt==PWM_DIV-1).
- PWM counter:
  - pwm_cnt[7:0] increments on step and wraps 255->0.
  - period_end = step && pwm_cnt==255.
- Individual duty:
  - ind[i] = (pwm_cnt < PWMi).
  - PWMi=0x00 gives always 0; 0xFF gives 255/256 high.
- Group gate, dim mode (MODE.dim_blink==0):
  - dim_cnt[7:0] increments on each period_end.
  - gate = (dim_cnt < GRPPWM).
- Group gate, blink mode (MODE.dim_blink==1):
  - sub_cnt counts 0..GRPFREQ on period_end.
  - On wrap, blink_phase[7:0] increments.
  - gate = (blink_phase < GRPPWM).
  - Blink period = 256*(GRPFREQ+1) PWM periods.
  - Toggling dim_blink clears dim_cnt, sub_cnt and blink_phase.
- Per-LED select (LEDOUT field LEDi, led_out_enum_t):
  - OFF -> 0, ON -> 1, INDIVIDUAL -> ind[i], GROUP -> ind[i] & gate.
- Invert: raw[i] ^= MODE.invert.
- Output timing:
  - led is registered, 1 clk after the counters.
  - MODE.output_change==0: led <= raw every clk.
  - MODE.output_change==1: led updates only on cycles with period_end (glitch-free duty changes).
- Sleep (sleep | MODE.sleep):
  - All counters held at 0.
  - led forced to {4{MODE.invert}} on the next edge, overriding output_change.
  - Register reads and writes still work.
  - Leaving sleep: counting restarts from 0.

Decomposition:
- Add to led_driver_pkg:
  - Register reset constants (e.g. GRPPWM_RST = 8'hFF).
  - A typedef for the group mode enum {GRP_DIM, GRP_BLINK}.
- Reuse existing types: reg_mode_t, reg_led_out_t, reg_enum_t.
- One natural sub-module: led_pwm_timebase.
  - Contains the prescaler, pwm_cnt, dim_cnt, sub_cnt and blink_phase.
  - Outputs pwm_cnt, period_end and gate.
- Top level keeps the register bank, bus tri-state and output mux.

Test Plan:
- Reset with all regs written 0xAA beforehand -> each address reads 00,00,00,00,00,FF,00,00; led=0; data=Z when idle.
- Write MODE=0xFF, then read -> 0xFE. Assert r_en and w_en together with data=0x12 at PWM1 -> PWM1=0x12, bus not driven by the DUT.
- PWM_DIV=1, PWM0=0x40, LEDOUT=0x02 -> led[0] high exactly 64 of every 256 clks. PWM0=0x00 -> never high. LEDOUT=0x01 -> constantly 1.
- LEDOUT=0x03, PWM0=0xFF, GRPPWM=0x80, dim mode -> led[0] active only while dim_cnt<128, i.e. the first 128 of every 256 periods.
- Blink: dim_blink=1, GRPFREQ=1, GRPPWM=0x80, LEDOUT=0x01<<6... use LED3=GROUP, PWM3=0xFF -> led[3] pattern period = 512 PWM periods, on for the first 256.
- MODE.invert=1, then sleep=1 -> led=4'b1111 next clk, counters 0. Set output_change=1 and change PWM0 mid-period -> led[0] duty changes only after the next pwm_cnt wrap.
